// File: rtl/i2c_slave_mem.sv
// I2C slave with a pointer-addressed byte memory (EEPROM-style), plus host-side rx/stop reporting.
// Optional SCL/SDA majority glitch filter enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_mem #(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22,
    parameter int MEM_DEPTH = 32,
    parameter int PTR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    output logic                      rx_valid,
    output logic [I2C_DATA_WIDTH-1:0] rx_data,
    output logic [PTR_WIDTH-1:0]      rx_ptr,
    output logic                      stop_det,
    output logic                      busy
);
    localparam int DW = I2C_DATA_WIDTH;
    localparam int AW = I2C_ADDR_WIDTH;
    localparam logic [3:0] NBITS = 4'(DW);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    state_t state, state_n;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_prev, sda_prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_filt, sda_filt;

    // 2-of-3 vote over the last three synchronized samples drops single-cycle pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_filt <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_filt <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end
    assign scl_s = scl_filt;
    assign sda_s = sda_filt;
`else
    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = scl_s & ~scl_prev;
    assign scl_fall = ~scl_s & scl_prev;
    assign start_ev = scl_s & scl_prev & ~sda_s & sda_prev;
    assign stop_ev  = scl_s & scl_prev & sda_s & ~sda_prev;

    logic [DW-1:0]        mem [MEM_DEPTH];
    logic [DW-1:0]        shreg, shreg_n, rd_byte;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [PTR_WIDTH-1:0] ptr, ptr_n;
    logic                 first_byte, first_byte_n, rw, rw_n;
    logic                 sda_n, busy_n, rx_valid_n, stop_det_n, mem_we;
    logic [DW-1:0]        rx_data_n;
    logic [PTR_WIDTH-1:0] rx_ptr_n;

    assign rd_byte = mem[ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bit_cnt_n    = bit_cnt;
        ptr_n        = ptr;
        first_byte_n = first_byte;
        rw_n         = rw;
        sda_n        = sda_o;
        busy_n       = busy;
        rx_valid_n   = 1'b0;
        rx_data_n    = rx_data;
        rx_ptr_n     = rx_ptr;
        stop_det_n   = 1'b0;
        mem_we       = 1'b0;
        if (stop_ev) begin
            state_n    = IDLE;
            sda_n      = 1'b1;
            stop_det_n = 1'b1;
            busy_n     = 1'b0;
        end else if (start_ev) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_n     = 1'b1;
            busy_n    = 1'b0;
        end else begin
            case (state)
                IDLE: sda_n = 1'b1;
                ADDR: begin
                    if (scl_rise && bit_cnt < NBITS) begin
                        shreg_n   = {shreg[DW-2:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == NBITS) begin
                        bit_cnt_n = '0;
                        if (shreg[DW-1 -: AW] == SLAVE_ADDR) begin
                            sda_n   = 1'b0;
                            busy_n  = 1'b1;
                            rw_n    = shreg[0];
                            state_n = ADDR_ACK;
                        end else begin
                            sda_n   = 1'b1;
                            state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!rw) begin
                            sda_n        = 1'b1;
                            first_byte_n = 1'b1;
                            bit_cnt_n    = '0;
                            state_n      = WR_BYTE;
                        end else begin
                            shreg_n   = rd_byte;
                            sda_n     = rd_byte[DW-1];
                            bit_cnt_n = 4'd1;
                            state_n   = RD_BYTE;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise && bit_cnt < NBITS) begin
                        shreg_n   = {shreg[DW-2:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == NBITS) begin
                        bit_cnt_n = '0;
                        sda_n     = 1'b0;
                        state_n   = WR_ACK;
                        if (first_byte) begin
                            ptr_n        = shreg[PTR_WIDTH-1:0];
                            first_byte_n = 1'b0;
                        end else begin
                            mem_we     = 1'b1;
                            rx_valid_n = 1'b1;
                            rx_data_n  = shreg;
                            rx_ptr_n   = ptr;
                            ptr_n      = ptr + 1'b1;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_n   = 1'b1;
                        state_n = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == NBITS) begin
                            sda_n     = 1'b1;
                            ptr_n     = ptr + 1'b1;
                            bit_cnt_n = '0;
                            state_n   = RD_ACK;
                        end else begin
                            shreg_n   = {shreg[DW-2:0], 1'b0};
                            sda_n     = shreg[DW-2];
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    // ptr already advanced past the byte just sent
                    if (scl_rise && sda_s) begin
                        state_n = IGNORE;
                    end else if (scl_fall) begin
                        shreg_n   = rd_byte;
                        sda_n     = rd_byte[DW-1];
                        bit_cnt_n = 4'd1;
                        state_n   = RD_BYTE;
                    end
                end
                IGNORE:  sda_n = 1'b1;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            ptr        <= '0;
            first_byte <= 1'b0;
            rw         <= 1'b0;
            sda_o      <= 1'b1;
            busy       <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_ptr     <= '0;
            stop_det   <= 1'b0;
        end else begin
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            ptr        <= ptr_n;
            first_byte <= first_byte_n;
            rw         <= rw_n;
            sda_o      <= sda_n;
            busy       <= busy_n;
            rx_valid   <= rx_valid_n;
            rx_data    <= rx_data_n;
            rx_ptr     <= rx_ptr_n;
            stop_det   <= stop_det_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) mem[ptr] <= shreg;
    end
endmodule
